// File: rtl/rv_imem_loader.sv
// rv_imem_loader
//   Boot-time program loader for rv_cpu. Receives a little-endian byte stream
//   (16-bit word count N, then N*4 image bytes, each word LSB first), writes
//   the image into instruction memory, fills the remaining words with NOPs,
//   waits a short hold period and then releases the CPU from reset.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   start         one-cycle load request (honoured in IDLE, DONE, ERR)
//   byte_valid    stream byte present
//   byte_data     stream byte
//   byte_ready    loader accepts the byte this cycle
//   imem_wr_en    IMEM write strobe
//   imem_wr_addr  word-aligned IMEM byte address
//   imem_wr_data  IMEM write data
//   cpu_rst       active-high reset to rv_cpu
//   done          load complete, CPU running
//   error         sticky: header word count larger than the IMEM
module rv_imem_loader #(
    parameter int unsigned IMEM_SIZE_WORDS = 256,
    parameter logic [31:0] NOP_WORD        = 32'h0000_0013,
    parameter int unsigned HOLD_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam int unsigned AW = $clog2(IMEM_SIZE_WORDS) + 1;
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [AW-1:0] SIZE_IDX = AW'(IMEM_SIZE_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(IMEM_SIZE_WORDS - 1);
    localparam logic [16:0]   SIZE_N   = 17'(IMEM_SIZE_WORDS);
    localparam logic [HW-1:0] HOLD_END = HW'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_FILL,
        S_HOLD,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic          hdr_cnt_q, hdr_cnt_d;
    logic [7:0]    n_lo_q, n_lo_d;
    logic [16:0]   n_q, n_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   shreg_q, shreg_d;
    logic [AW-1:0] word_idx_q, word_idx_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    logic          wr_en_d;
    logic [31:0]   wr_addr_d;
    logic [31:0]   wr_data_d;

    logic          xfer;
    logic [15:0]   hdr_n;
    logic [AW-1:0] idx_next;
    logic [31:0]   idx_addr;

    assign xfer     = byte_valid && byte_ready;
    assign hdr_n    = {byte_data, n_lo_q};
    assign idx_next = word_idx_q + AW'(1);
    assign idx_addr = 32'({word_idx_q, 2'b00});

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        n_lo_d     = n_lo_q;
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        word_idx_d = word_idx_q;
        hold_cnt_d = hold_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = imem_wr_addr;
        wr_data_d  = imem_wr_data;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR;
                    hdr_cnt_d  = 1'b0;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                end
            end

            S_HDR: begin
                if (xfer) begin
                    if (!hdr_cnt_q) begin
                        n_lo_d    = byte_data;
                        hdr_cnt_d = 1'b1;
                    end else begin
                        n_d = 17'(hdr_n);
                        if (17'(hdr_n) > SIZE_N) begin
                            state_d = S_ERR;
                        end else if (hdr_n == '0) begin
                            state_d = S_FILL;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Earlier bytes sit in the low lanes, this one is the MSB.
                        wr_en_d    = 1'b1;
                        wr_addr_d  = idx_addr;
                        wr_data_d  = {byte_data, shreg_q};
                        word_idx_d = idx_next;
                        if (17'(idx_next) == n_q) begin
                            state_d = S_FILL;
                        end
                    end else begin
                        shreg_d = {byte_data, shreg_q[23:8]};
                    end
                end
            end

            S_FILL: begin
                if (word_idx_q == SIZE_IDX) begin
                    // Image filled the whole IMEM: the last write happened in
                    // this cycle, so this cycle already counts toward the hold.
                    state_d    = S_HOLD;
                    hold_cnt_d = HW'(1);
                end else begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = idx_addr;
                    wr_data_d  = NOP_WORD;
                    word_idx_d = idx_next;
                    if (word_idx_q == LAST_IDX) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end

            S_HOLD: begin
                // hold_cnt counts cycles since the final write became visible.
                if (hold_cnt_q == HOLD_END) begin
                    state_d = S_DONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hdr_cnt_q    <= 1'b0;
            n_lo_q       <= '0;
            n_q          <= '0;
            byte_cnt_q   <= '0;
            shreg_q      <= '0;
            word_idx_q   <= '0;
            hold_cnt_q   <= '0;
            byte_ready   <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            n_lo_q       <= n_lo_d;
            n_q          <= n_d;
            byte_cnt_q   <= byte_cnt_d;
            shreg_q      <= shreg_d;
            word_idx_q   <= word_idx_d;
            hold_cnt_q   <= hold_cnt_d;
            // Status outputs are registered images of the next state.
            byte_ready   <= (state_d == S_HDR) || (state_d == S_DATA);
            imem_wr_en   <= wr_en_d;
            imem_wr_addr <= wr_addr_d;
            imem_wr_data <= wr_data_d;
            cpu_rst      <= (state_d != S_DONE);
            done         <= (state_d == S_DONE);
            error        <= (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_rv_imem_loader.sv
// tb_rv_imem_loader
//   Self-checking bench for rv_imem_loader. Streams randomised images (with
//   optional random byte gaps) and compares the observed IMEM write sequence,
//   write timing and CPU release timing against an expected image built from
//   the stream contents.
module tb_rv_imem_loader;

    localparam int unsigned SIZE = 256;
    localparam int unsigned HOLD = 4;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        cpu_rst;
    logic        done;
    logic        error;

    rv_imem_loader #(
        .IMEM_SIZE_WORDS(SIZE),
        .NOP_WORD(NOP),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .imem_wr_en(imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .cpu_rst(cpu_rst),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] img [SIZE];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    int          acc_q     [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Write monitor: every write is logged, and a write must only occur
    // while the CPU is held in reset and the load is not yet complete.
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            wr_addr_q.push_back(imem_wr_addr);
            wr_data_q.push_back(imem_wr_data);
            wr_cyc_q.push_back(cyc);
            check("wr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            check("wr_done", {31'd0, done}, 32'd0);
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        acc_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},  {31'd0, byte_ready}, 32'd0);
        check({tag, "_wen"},  {31'd0, imem_wr_en}, 32'd0);
        check({tag, "_addr"}, imem_wr_addr, 32'd0);
        check({tag, "_data"}, imem_wr_data, 32'd0);
        check({tag, "_crst"}, {31'd0, cpu_rst}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"},  {31'd0, error}, 32'd0);
    endtask

    // Called #1 after a posedge. Leaves byte_valid low #1 after the edge
    // on which the byte was taken; logs that edge number.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        while (gap > 0 && $urandom_range(99) < gap) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!byte_ready) begin
            check("rdy_timeout", {31'd0, byte_ready}, 32'd1);
            byte_valid = 1'b0;
            return;
        end
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_load(input int n, input int gap);
        logic [15:0] nn;
        logic [31:0] w;
        logic [31:0] exp_d;
        int g;
        int done_cyc;
        clear_logs();
        nn = 16'(n);
        pulse_start();
        check("start_rdy",  {31'd0, byte_ready}, 32'd1);
        check("start_crst", {31'd0, cpu_rst}, 32'd1);
        check("start_done", {31'd0, done}, 32'd0);
        check("start_err",  {31'd0, error}, 32'd0);
        send_byte(nn[7:0], gap);
        send_byte(nn[15:8], gap);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
        end
        g = 0;
        while (done !== 1'b1 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("done", {31'd0, done}, 32'd1);
        done_cyc = cyc;
        check("done_crst", {31'd0, cpu_rst}, 32'd0);
        check("done_err",  {31'd0, error}, 32'd0);
        check("wr_count", wr_addr_q.size(), SIZE);
        check("acc_count", acc_q.size(), 2 + 4 * n);
        if (wr_addr_q.size() == SIZE && acc_q.size() == 2 + 4 * n) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                exp_d = (i < n) ? img[i] : NOP;
                check($sformatf("wr_addr[%0d]", i), wr_addr_q[i], 32'(i * 4));
                check($sformatf("wr_data[%0d]", i), wr_data_q[i], exp_d);
                if (i < n)
                    check($sformatf("wr_lat[%0d]", i), wr_cyc_q[i], acc_q[2 + 4 * i + 3]);
                else if (i > 0)
                    check($sformatf("fill_gap[%0d]", i), wr_cyc_q[i], wr_cyc_q[i - 1] + 1);
            end
            check("release_lat", done_cyc - wr_cyc_q[SIZE - 1], HOLD + 1);
        end
    endtask

    initial begin
        int nwr4;
        int n;

        #2 rst_n = 1'b0;
        #20;
        check_reset_vals("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        // Basic three-instruction program, full rate then with gaps.
        img[0] = 32'h0050_0093;
        img[1] = 32'h00A0_0113;
        img[2] = 32'h0020_8233;
        do_load(3, 0);
        do_load(3, 50);

        // Empty image: all NOPs.
        do_load(0, 0);

        // Full image: no NOP fill.
        for (int i = 0; i < int'(SIZE); i++) img[i] = $urandom();
        do_load(256, 0);

        // Oversized header.
        clear_logs();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        check("ovf_err",  {31'd0, error}, 32'd1);
        check("ovf_rdy",  {31'd0, byte_ready}, 32'd0);
        check("ovf_crst", {31'd0, cpu_rst}, 32'd1);
        check("ovf_cyc",  cyc, acc_q[1]);
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (10) @(negedge clk);
        check("ovf_rdy_hold", {31'd0, byte_ready}, 32'd0);
        check("ovf_err_hold", {31'd0, error}, 32'd1);
        byte_valid = 1'b0;
        check("ovf_nowr", wr_addr_q.size(), 0);
        n = $urandom_range(1, 255);
        do_load(n, 30);

        // Reset in the middle of the second image word.
        img[0] = 32'h0050_0093;
        img[1] = 32'h00A0_0113;
        img[2] = 32'h0020_8233;
        clear_logs();
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int b = 0; b < 6; b++) begin
            logic [63:0] pair;
            pair = {img[1], img[0]};
            send_byte(pair[8*b +: 8], 0);
        end
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("midrst");
        end
        nwr4 = 0;
        foreach (wr_addr_q[i]) if (wr_addr_q[i] == 32'h4) nwr4++;
        check("midrst_no_wr4", nwr4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_load(3, 0);

        // A couple of random images with gaps.
        repeat (2) begin
            for (int i = 0; i < int'(SIZE); i++) img[i] = $urandom();
            n = $urandom_range(1, 255);
            do_load(n, 40);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
